// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, per-instruction condition latch and write-strobe gating.
// Optional macro COND_STATS_EN adds saturating executed/skipped instruction counters.
module cond_unit #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             CondLatch,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    output logic [3:0]       Flags,
    output logic             CondEx,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] ExecCnt,
    output logic [CNT_W-1:0] SkipCnt
`endif
);

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    res = z;
            4'h1:    res = ~z;
            4'h2:    res = c;
            4'h3:    res = ~c;
            4'h4:    res = n;
            4'h5:    res = ~n;
            4'h6:    res = v;
            4'h7:    res = ~v;
            4'h8:    res = c & ~z;
            4'h9:    res = ~c | z;
            4'hA:    res = (n == v);
            4'hB:    res = (n != v);
            4'hC:    res = ~z & (n == v);
            4'hD:    res = z | (n != v);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    logic [3:0] r_flags;
    logic       r_cond_ex;
    logic       w_cond_pass;

    // Condition is judged against the registered flags, never the live ALU flags
    always_comb begin
        w_cond_pass = cond_eval(Cond, r_flags);
    end

    // Condition latch and NZCV register; flag writes are qualified by the held CondEx
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags   <= FLAGS_RST;
            r_cond_ex <= 1'b0;
        end else begin
            if (CondLatch) begin
                r_cond_ex <= w_cond_pass;
            end
            if (FlagW[1] && r_cond_ex) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && r_cond_ex) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign Flags    = r_flags;
    assign CondEx   = r_cond_ex;
    assign PCWrite  = NextPC | (PCS & r_cond_ex);
    assign RegWrite = RegW & r_cond_ex;
    assign MemWrite = MemW & r_cond_ex;

`ifdef COND_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_exec_cnt;
    logic [CNT_W-1:0] r_skip_cnt;

    // One counter steps per latch; both stick at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt <= {CNT_W{1'b0}};
            r_skip_cnt <= {CNT_W{1'b0}};
        end else if (CondLatch) begin
            if (w_cond_pass) begin
                if (r_exec_cnt != CNT_MAX) begin
                    r_exec_cnt <= r_exec_cnt + CNT_ONE;
                end
            end else begin
                if (r_skip_cnt != CNT_MAX) begin
                    r_skip_cnt <= r_skip_cnt + CNT_ONE;
                end
            end
        end
    end

    assign ExecCnt = r_exec_cnt;
    assign SkipCnt = r_skip_cnt;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = {CNT_W{1'b0}};
`endif

endmodule
